// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared widths, limits and state encoding for the program loader
// Contents: default address/data widths, largest legal word count, default
// inter-byte timeout, the 3-bit loader state enum and a busy-state helper.
package imem_loader_pkg;
  localparam int LDR_ADDR_WIDTH     = 12;
  localparam int LDR_DATA_WIDTH     = 32;
  localparam int LDR_BYTES_PER_WORD = 4;
  localparam int LDR_MAX_WORDS      = (1 << LDR_ADDR_WIDTH) / LDR_BYTES_PER_WORD;
  localparam int LDR_TIMEOUT        = 1000000;
  typedef enum logic [2:0] {
    LDR_IDLE = 3'd0,
    LDR_LEN1 = 3'd1,
    LDR_DATA = 3'd2,
    LDR_CSUM = 3'd3,
    LDR_DONE = 3'd4,
    LDR_ERR  = 3'd5
  } ldr_state_e;
  // states inside a frame, where the inter-byte timeout is armed
  function automatic logic ldr_busy(ldr_state_e s);
    return s == LDR_LEN1 || s == LDR_DATA || s == LDR_CSUM;
  endfunction
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream in, instruction-memory write port out
// Signals: s_dat/s_valid/s_ready byte stream handshake; w_addr/w_dat/w_enb/byte_enb
// i_mem write port. Modport master = stream source / memory, slave = loader.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = LDR_ADDR_WIDTH,
  parameter int DATA_WIDTH = LDR_DATA_WIDTH
);
  logic [7:0]            s_dat;
  logic                  s_valid;
  logic                  s_ready;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_dat;
  logic                  w_enb;
  logic [3:0]            byte_enb;
  modport master (output s_dat, s_valid, input s_ready, w_addr, w_dat, w_enb, byte_enb);
  modport slave  (input s_dat, s_valid, output s_ready, w_addr, w_dat, w_enb, byte_enb);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream program loader, writer side of the instruction RAM
// Ports: clk, rst_n (async, active-low); bus (slave) carries the byte stream and the
// i_mem write port; i_restart leaves DONE/ERR; o_pc_stall holds the CPU until a frame
// loads with a good checksum; o_done/o_error frame status; o_words_loaded word count.
// Frame: LEN_LO, LEN_HI, N little-endian words, then XOR of all data bytes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH  = LDR_ADDR_WIDTH,
  parameter int DATA_WIDTH  = LDR_DATA_WIDTH,
  parameter int MAX_WORDS   = LDR_MAX_WORDS,
  parameter int TIMEOUT_CYC = LDR_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  imem_loader_if.slave        bus,
  input  logic                i_restart,
  output logic                o_pc_stall,
  output logic                o_done,
  output logic                o_error,
  output logic [15:0]         o_words_loaded
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  ldr_state_e            r_state;
  logic                  r_ready, r_stall, r_done, r_error, r_wenb;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_word, r_wdat;
  logic [1:0]            r_bcnt;
  logic [7:0]            r_xor, r_len_lo;
  logic [15:0]           r_len, r_words;
  logic [TW-1:0]         r_tcnt;
  logic                  w_acc, w_tmo, w_last;
  logic [15:0]           w_len;
  logic [DATA_WIDTH-1:0] w_shift;
  assign w_acc   = bus.s_valid & r_ready;
  assign w_len   = {bus.s_dat, r_len_lo};
  // the counter holds the number of idle cycles already seen, so this edge is the TIMEOUT_CYC-th
  assign w_tmo   = r_tcnt == TW'(TIMEOUT_CYC - 1);
  assign w_last  = r_words + 16'd1 == r_len;
  // little-endian assembly: new byte enters at the top, byte0 ends at [7:0]
  assign w_shift = {bus.s_dat, r_word[DATA_WIDTH-1:8]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= LDR_IDLE;
      r_ready  <= 1'b1;
      r_stall  <= 1'b1;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_wenb   <= 1'b0;
      r_addr   <= '0;
      r_wdat   <= '0;
      r_word   <= '0;
      r_bcnt   <= '0;
      r_xor    <= '0;
      r_len_lo <= '0;
      r_len    <= '0;
      r_words  <= '0;
      r_tcnt   <= '0;
    end else begin
      r_wenb <= 1'b0;
      if (w_acc) r_tcnt <= '0;
      else if (ldr_busy(r_state)) r_tcnt <= r_tcnt + 1'b1;
      case (r_state)
        LDR_IDLE: if (w_acc) begin
          r_len_lo <= bus.s_dat;
          r_state  <= LDR_LEN1;
        end
        LDR_LEN1: if (w_acc) begin
          r_len  <= w_len;
          r_bcnt <= '0;
          if (w_len > 16'(MAX_WORDS)) begin
            r_state <= LDR_ERR;
            r_error <= 1'b1;
            r_ready <= 1'b0;
          end else r_state <= w_len == 16'd0 ? LDR_CSUM : LDR_DATA;
        end
        LDR_DATA: if (w_acc) begin
          r_xor  <= r_xor ^ bus.s_dat;
          r_bcnt <= r_bcnt + 2'd1;
          r_word <= w_shift;
          if (r_bcnt == 2'd3) begin
            r_wenb  <= 1'b1;
            r_wdat  <= w_shift;
            r_addr  <= ADDR_WIDTH'({r_words, 2'b00});
            r_words <= r_words + 16'd1;
            if (w_last) r_state <= LDR_CSUM;
          end
        end
        LDR_CSUM: if (w_acc) begin
          r_ready <= 1'b0;
          if (bus.s_dat == r_xor) begin
            r_state <= LDR_DONE;
            r_done  <= 1'b1;
            r_stall <= 1'b0;
          end else begin
            r_state <= LDR_ERR;
            r_error <= 1'b1;
          end
        end
        LDR_DONE, LDR_ERR: if (i_restart) begin
          r_state <= LDR_IDLE;
          r_ready <= 1'b1;
          r_stall <= 1'b1;
          r_done  <= 1'b0;
          r_error <= 1'b0;
          r_words <= '0;
          r_xor   <= '0;
        end
        default: r_state <= LDR_IDLE;
      endcase
      // a stalled stream inside a frame aborts it; an accepted byte always restarts the count
      if (!w_acc && w_tmo && ldr_busy(r_state)) begin
        r_state <= LDR_ERR;
        r_error <= 1'b1;
        r_ready <= 1'b0;
      end
    end
  end
  assign bus.s_ready    = r_ready;
  assign bus.w_addr     = r_addr;
  assign bus.w_dat      = r_wdat;
  assign bus.w_enb      = r_wenb;
  assign bus.byte_enb   = {4{r_wenb}};
  assign o_pc_stall     = r_stall;
  assign o_done         = r_done;
  assign o_error        = r_error;
  assign o_words_loaded = r_words;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frame-level checks of imem_loader against a byte/word model
module tb_imem_loader;
  import imem_loader_pkg::*;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int MW = 8;
  localparam int TO = 16;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_restart = 1'b0;
  logic        o_pc_stall, o_done, o_error;
  logic [15:0] o_words_loaded;
  imem_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WORDS(MW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .i_restart(i_restart),
    .o_pc_stall(o_pc_stall), .o_done(o_done), .o_error(o_error), .o_words_loaded(o_words_loaded)
  );
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  int benb_bad = 0;
  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  logic [31:0]   exp_words[$];
  logic [7:0]    fb_q[$];
  logic [DW-1:0] ram [MW];
  // memory-side observer: records every write strobe and byte-enable consistency
  always @(negedge clk) begin
    if (bus.byte_enb !== (bus.w_enb === 1'b1 ? 4'hf : 4'h0)) benb_bad++;
    if (bus.w_enb === 1'b1) begin
      wa_q.push_back(bus.w_addr);
      wd_q.push_back(bus.w_dat);
      if (int'(bus.w_addr[AW-1:2]) < MW) ram[int'(bus.w_addr[AW-1:2])] = bus.w_dat;
    end
  end
  task automatic send_byte(input logic [7:0] b, input int gap);
    if (gap > 0) begin
      @(negedge clk);
      bus.s_valid = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
    @(negedge clk);
    bus.s_dat   = b;
    bus.s_valid = 1'b1;
  endtask
  task automatic idle_bus();
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask
  task automatic pulse_restart();
    @(negedge clk);
    i_restart = 1'b1;
    @(negedge clk);
    i_restart = 1'b0;
    @(negedge clk);
  endtask
  // frame bytes from exp_words; checksum is XOR of all data bytes, then corrupted by delta
  task automatic make_frame(input logic [7:0] delta);
    logic [7:0] x;
    int n;
    n = exp_words.size();
    x = 8'h00;
    fb_q.delete();
    fb_q.push_back(n[7:0]);
    fb_q.push_back(n[15:8]);
    foreach (exp_words[i])
      for (int j = 0; j < 4; j++) begin
        fb_q.push_back(exp_words[i][8*j +: 8]);
        x ^= exp_words[i][8*j +: 8];
      end
    fb_q.push_back(x ^ delta);
  endtask
  task automatic send_frame(input int max_gap, input int rst_at);
    wa_q.delete();
    wd_q.delete();
    foreach (fb_q[i]) begin
      i_restart = (i == rst_at);
      send_byte(fb_q[i], int'($urandom_range(max_gap, 0)));
    end
    i_restart = 1'b0;
    idle_bus();
    repeat (2) @(negedge clk);
  endtask
  task automatic test_reset();
    bus.s_valid = 1'b0;
    bus.s_dat   = 8'h00;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (bus.s_ready !== 1'b1) begin fails++; $display("FAIL reset_s_ready got %b want 1", bus.s_ready); end
    tests++; if (o_pc_stall !== 1'b1) begin fails++; $display("FAIL reset_pc_stall got %b want 1", o_pc_stall); end
    tests++; if (o_done !== 1'b0 || o_error !== 1'b0) begin fails++; $display("FAIL reset_status got done=%b err=%b want 0 0", o_done, o_error); end
    tests++; if (bus.w_enb !== 1'b0 || bus.byte_enb !== 4'h0) begin fails++; $display("FAIL reset_wenb got %b/%h want 0/0", bus.w_enb, bus.byte_enb); end
    tests++; if (bus.w_addr !== '0 || bus.w_dat !== '0 || o_words_loaded !== 16'd0) begin fails++; $display("FAIL reset_zero got addr=%h dat=%h wl=%0d want 0", bus.w_addr, bus.w_dat, o_words_loaded); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_example(input logic bad);
    logic [7:0] ex [11];
    ex = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    if (bad) ex[10] = 8'h00;
    wa_q.delete();
    wd_q.delete();
    for (int i = 0; i < 11; i++) send_byte(ex[i], 0);
    idle_bus();
    repeat (2) @(negedge clk);
    tests++; if (wa_q.size() != 2) begin fails++; $display("FAIL ex_writes got %0d want 2", wa_q.size()); end
    tests++; if (wa_q[0] !== 12'h000 || wd_q[0] !== 32'h00000013) begin fails++; $display("FAIL ex_word0 got %h@%h want 00000013@000", wd_q[0], wa_q[0]); end
    tests++; if (wa_q[1] !== 12'h004 || wd_q[1] !== 32'h00100093) begin fails++; $display("FAIL ex_word1 got %h@%h want 00100093@004", wd_q[1], wa_q[1]); end
    tests++; if (o_done !== !bad || o_error !== bad) begin fails++; $display("FAIL ex_status got done=%b err=%b want %b %b", o_done, o_error, !bad, bad); end
    tests++; if (o_pc_stall !== bad || bus.s_ready !== 1'b0) begin fails++; $display("FAIL ex_stall got stall=%b rdy=%b want %b 0", o_pc_stall, bus.s_ready, bad); end
    tests++; if (o_words_loaded !== 16'd2) begin fails++; $display("FAIL ex_words got %0d want 2", o_words_loaded); end
    repeat (5) @(negedge clk);
    tests++; if (o_done !== !bad || o_error !== bad) begin fails++; $display("FAIL ex_sticky got done=%b err=%b", o_done, o_error); end
    pulse_restart();
    tests++; if (o_done !== 1'b0 || o_error !== 1'b0 || o_pc_stall !== 1'b1 || bus.s_ready !== 1'b1) begin fails++; $display("FAIL ex_restart got done=%b err=%b stall=%b rdy=%b want 0 0 1 1", o_done, o_error, o_pc_stall, bus.s_ready); end
    tests++; if (o_words_loaded !== 16'd0) begin fails++; $display("FAIL ex_restart_words got %0d want 0", o_words_loaded); end
  endtask
  task automatic test_len_bounds();
    int ov;
    exp_words.delete();
    make_frame(8'h00);
    send_frame(0, -1);
    tests++; if (o_done !== 1'b1 || wa_q.size() != 0 || o_words_loaded !== 16'd0) begin fails++; $display("FAIL len0 got done=%b writes=%0d wl=%0d want 1 0 0", o_done, wa_q.size(), o_words_loaded); end
    pulse_restart();
    for (int i = 0; i < MW; i++) exp_words.push_back($urandom);
    make_frame(8'h00);
    send_frame(1, -1);
    tests++; if (o_done !== 1'b1 || wa_q.size() != MW) begin fails++; $display("FAIL lenmax got done=%b writes=%0d want 1 %0d", o_done, wa_q.size(), MW); end
    for (int i = 0; i < MW; i++) begin
      tests++; if (wa_q[i] !== AW'(i * 4) || wd_q[i] !== exp_words[i]) begin fails++; $display("FAIL lenmax_w%0d got %h@%h want %h@%h", i, wd_q[i], wa_q[i], exp_words[i], AW'(i * 4)); end
    end
    pulse_restart();
    ov = MW + 1;
    wa_q.delete();
    send_byte(ov[7:0], 0);
    send_byte(ov[15:8], 0);
    idle_bus();
    tests++; if (o_error !== 1'b1 || bus.s_ready !== 1'b0) begin fails++; $display("FAIL lenover got err=%b rdy=%b want 1 0", o_error, bus.s_ready); end
    repeat (3) @(negedge clk);
    tests++; if (wa_q.size() != 0 || o_done !== 1'b0) begin fails++; $display("FAIL lenover_writes got %0d done=%b want 0 0", wa_q.size(), o_done); end
    pulse_restart();
  endtask
  task automatic test_timeout();
    exp_words.delete();
    exp_words.push_back($urandom);
    exp_words.push_back($urandom);
    make_frame(8'h00);
    wa_q.delete();
    wd_q.delete();
    foreach (fb_q[i]) send_byte(fb_q[i], i == 5 ? TO - 1 : 0);
    idle_bus();
    repeat (2) @(negedge clk);
    tests++; if (o_done !== 1'b1 || o_error !== 1'b0) begin fails++; $display("FAIL tmo_short_gap got done=%b err=%b want 1 0", o_done, o_error); end
    pulse_restart();
    for (int i = 0; i < 5; i++) send_byte(fb_q[i], 0);
    @(negedge clk);
    bus.s_valid = 1'b0;
    repeat (TO - 1) @(negedge clk);
    tests++; if (o_error !== 1'b0) begin fails++; $display("FAIL tmo_before got err=%b want 0", o_error); end
    @(negedge clk);
    tests++; if (o_error !== 1'b1 || o_pc_stall !== 1'b1 || bus.s_ready !== 1'b0) begin fails++; $display("FAIL tmo_err got err=%b stall=%b rdy=%b want 1 1 0", o_error, o_pc_stall, bus.s_ready); end
    pulse_restart();
    repeat (3 * TO) @(negedge clk);
    tests++; if (o_error !== 1'b0 || bus.s_ready !== 1'b1) begin fails++; $display("FAIL tmo_idle got err=%b rdy=%b want 0 1", o_error, bus.s_ready); end
  endtask
  task automatic test_reset_midframe();
    exp_words.delete();
    for (int i = 0; i < 3; i++) exp_words.push_back($urandom);
    make_frame(8'h00);
    wa_q.delete();
    wd_q.delete();
    for (int i = 0; i < 8; i++) send_byte(fb_q[i], 0);
    @(negedge clk);
    bus.s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++; if (o_pc_stall !== 1'b1 || bus.s_ready !== 1'b1 || o_words_loaded !== 16'd0) begin fails++; $display("FAIL midrst got stall=%b rdy=%b wl=%0d want 1 1 0", o_pc_stall, bus.s_ready, o_words_loaded); end
    tests++; if (wa_q.size() != 1 || wd_q[0] !== exp_words[0]) begin fails++; $display("FAIL midrst_partial got %0d writes first=%h want 1 %h", wa_q.size(), wd_q[0], exp_words[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_words.delete();
    for (int i = 0; i < 3; i++) exp_words.push_back($urandom);
    make_frame(8'h00);
    send_frame(0, -1);
    tests++; if (o_done !== 1'b1 || wa_q.size() != 3) begin fails++; $display("FAIL midrst_reload got done=%b writes=%0d want 1 3", o_done, wa_q.size()); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (wa_q[i] !== AW'(i * 4) || wd_q[i] !== exp_words[i]) begin fails++; $display("FAIL midrst_w%0d got %h@%h want %h@%h", i, wd_q[i], wa_q[i], exp_words[i], AW'(i * 4)); end
    end
    pulse_restart();
  endtask
  task automatic test_random();
    int n;
    int ra;
    logic [7:0] d;
    for (int it = 0; it < 20; it++) begin
      n = int'($urandom_range(MW, 0));
      d = ($urandom_range(1, 0) == 0) ? 8'h00 : 8'($urandom_range(255, 1));
      ra = n > 0 ? int'($urandom_range(1 + 4 * n, 2)) : -1;
      exp_words.delete();
      for (int i = 0; i < n; i++) exp_words.push_back($urandom);
      make_frame(d);
      send_frame(3, ra);
      tests++; if (wa_q.size() != n) begin fails++; $display("FAIL rnd%0d_writes got %0d want %0d", it, wa_q.size(), n); end
      for (int i = 0; i < n; i++) begin
        tests++; if (wa_q[i] !== AW'(i * 4) || wd_q[i] !== exp_words[i]) begin fails++; $display("FAIL rnd%0d_w%0d got %h@%h want %h@%h", it, i, wd_q[i], wa_q[i], exp_words[i], AW'(i * 4)); end
      end
      tests++; if (o_done !== (d == 8'h00) || o_error !== (d != 8'h00) || o_pc_stall !== (d != 8'h00)) begin fails++; $display("FAIL rnd%0d_status got done=%b err=%b stall=%b csum_ok=%b", it, o_done, o_error, o_pc_stall, d == 8'h00); end
      tests++; if (o_words_loaded !== 16'(n)) begin fails++; $display("FAIL rnd%0d_wl got %0d want %0d", it, o_words_loaded, n); end
      pulse_restart();
      tests++; if (o_words_loaded !== 16'd0 || bus.s_ready !== 1'b1) begin fails++; $display("FAIL rnd%0d_restart got wl=%0d rdy=%b want 0 1", it, o_words_loaded, bus.s_ready); end
    end
  endtask
  task automatic test_integration();
    for (int i = 0; i < MW; i++) ram[i] = '0;
    exp_words = '{32'h00500093, 32'h00700113, 32'h002081b3, 32'h00302023,
                  32'h00002203, 32'h00120213, 32'hfe5ff06f, 32'h00000013};
    make_frame(8'h00);
    send_frame(2, -1);
    tests++; if (o_pc_stall !== 1'b0) begin fails++; $display("FAIL prog_release got stall=%b want 0", o_pc_stall); end
    for (int i = 0; i < MW; i++) begin
      tests++; if (ram[i] !== exp_words[i]) begin fails++; $display("FAIL prog_mem%0d got %h want %h", i, ram[i], exp_words[i]); end
    end
    tests++; if (benb_bad != 0) begin fails++; $display("FAIL byte_enb got %0d bad cycles want 0", benb_bad); end
  endtask
  initial begin
    test_reset();
    test_example(1'b0);
    test_example(1'b1);
    test_len_bounds();
    test_timeout();
    test_reset_midframe();
    test_random();
    test_integration();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
